alu_issue_seq: RTL and testbench

//  Micro-op issue sequencer that drives the ALU. It accepts 16-bit instructions over a

---
 rtl/alu_issue_seq_if.sv | 30 +++
 rtl/alu_issue_seq.sv | 135 +++++++++++++
 tb/tb_alu_issue_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_seq_if.sv
// rtl/alu_issue_seq_if.sv - instruction handshake, ALU bus and debug port bundle
interface alu_issue_seq_if #(
  parameter int DW = 32
);
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [DW-1:0] alu_lhs;
  logic [DW-1:0] alu_rhs;
  logic [4:0]    alu_uop;
  logic [DW-1:0] alu_out;
  logic [3:0]    alu_flags;
  logic [3:0]    flags;
  logic          done;
  logic          err;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  // sequencer side
  modport slave (
    input  instr_valid, instr, alu_out, alu_flags, dbg_addr,
    output instr_ready, alu_lhs, alu_rhs, alu_uop, flags, done, err, dbg_data
  );

  // fetch / ALU / debug side
  modport master (
    output instr_valid, instr, alu_out, alu_flags, dbg_addr,
    input  instr_ready, alu_lhs, alu_rhs, alu_uop, flags, done, err, dbg_data
  );
endinterface

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - four-state micro-op issue sequencer with 8x32 register file
module alu_issue_seq #(
  parameter int NREG = 8,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] lhs_q, lhs_d;
  logic [DW-1:0] rhs_q, rhs_d;
  logic [4:0]    uop_q, uop_d;
  logic          illegal_q, illegal_d;
  logic          we_q, we_d;
  logic [DW-1:0] res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  // instruction field views of the latched word
  logic [3:0] op;
  logic       imm;
  logic [2:0] rd, rn, rm;

  // next-state, decode, writeback and output logic
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    uop_d     = uop_q;
    illegal_d = illegal_q;
    we_d      = we_q;
    res_d     = res_q;
    flags_d   = flags_q;
    for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];

    op  = instr_q[15:12];
    imm = instr_q[11];
    rd  = instr_q[10:8];
    rn  = instr_q[7:5];
    rm  = instr_q[4:2];

    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (imm) begin
          lhs_d = rf_q[rd];
          rhs_d = {{(DW-8){1'b0}}, instr_q[7:0]};
        end else begin
          lhs_d = rf_q[rn];
          rhs_d = rf_q[rm];
        end
        if (op > 4'd8) begin
          // illegal opcodes still walk the pipeline but drive a NOP to the ALU
          uop_d     = 5'd0;
          illegal_d = 1'b1;
          we_d      = 1'b0;
        end else begin
          uop_d     = {1'b0, op};
          illegal_d = 1'b0;
          we_d      = (op != 4'd0) && (op != 4'd5);
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = bus.alu_out;
        if (uop_q != 5'd0) flags_d = bus.alu_flags;
        state_d = S_WB;
      end
      S_WB: begin
        bus.done = 1'b1;
        bus.err  = illegal_q;
        if (we_q) rf_d[rd] = res_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // the ALU only sees a live uop during EXEC so it keeps its flags otherwise
    bus.alu_uop  = (state_q == S_EXEC) ? uop_q : 5'd0;
    bus.alu_lhs  = lhs_q;
    bus.alu_rhs  = rhs_q;
    bus.flags    = flags_q;
    bus.dbg_data = rf_q[bus.dbg_addr];
  end

  // state and datapath registers; reset discards any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      uop_q     <= '0;
      illegal_q <= 1'b0;
      we_q      <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      uop_q     <= uop_d;
      illegal_q <= illegal_d;
      we_q      <= we_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed self-checking bench for alu_issue_seq
module tb_alu_issue_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_issue_seq_if #(.DW(32)) bus ();

  alu_issue_seq #(.NREG(8), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // reference ALU: carry on subtract means "no borrow"
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide      = 33'd0;
    bus.alu_out   = 32'd0;
    bus.alu_flags = 4'd0;
    case (bus.alu_uop)
      5'd1: begin
        alu_wide         = {1'b0, bus.alu_lhs} + {1'b0, bus.alu_rhs};
        bus.alu_out      = alu_wide[31:0];
        bus.alu_flags[2] = alu_wide[32];
        bus.alu_flags[0] = (bus.alu_lhs[31] == bus.alu_rhs[31]) && (alu_wide[31] != bus.alu_lhs[31]);
      end
      5'd2, 5'd5: begin
        bus.alu_out      = bus.alu_lhs - bus.alu_rhs;
        bus.alu_flags[2] = bus.alu_lhs >= bus.alu_rhs;
        bus.alu_flags[0] = (bus.alu_lhs[31] != bus.alu_rhs[31]) && (bus.alu_out[31] != bus.alu_lhs[31]);
      end
      5'd3: bus.alu_out = bus.alu_lhs & bus.alu_rhs;
      5'd4: bus.alu_out = bus.alu_lhs ^ bus.alu_rhs;
      5'd6: bus.alu_out = bus.alu_lhs << bus.alu_rhs[4:0];
      5'd7: bus.alu_out = bus.alu_lhs >> bus.alu_rhs[4:0];
      5'd8: bus.alu_out = bus.alu_rhs;
      default: bus.alu_out = 32'd0;
    endcase
    if (bus.alu_uop != 5'd0) begin
      bus.alu_flags[3] = (bus.alu_out == 32'd0);
      bus.alu_flags[1] = bus.alu_out[31];
    end
  end

  logic        rdy_dec, done_ex, done_wb, err_wb, done_idle;
  logic [4:0]  uop_ex;
  logic [31:0] lhs_ex, rhs_ex;
  logic [31:0] rdv;
  logic [31:0] exp_rf [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.dbg_addr = a;
    #1;
    d = bus.dbg_data;
  endtask

  // called at +1 after a rising edge with the sequencer in IDLE
  task automatic issue(input logic [15:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    rdy_dec = bus.instr_ready;
    @(posedge clk); #1;
    uop_ex  = bus.alu_uop;
    lhs_ex  = bus.alu_lhs;
    rhs_ex  = bus.alu_rhs;
    done_ex = bus.done;
    @(posedge clk); #1;
    done_wb = bus.done;
    err_wb  = bus.err;
    @(posedge clk); #1;
    done_idle = bus.done;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], rdv);
      chk(tag, rdv, exp_rf[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rdy_hist;
    int          accepts;
    int          dones;

    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.dbg_addr    = 3'd0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_done",  {31'd0, bus.done}, 32'd0);
    chk("rst_err",   {31'd0, bus.err}, 32'd0);
    chk("rst_flags", {28'd0, bus.flags}, 32'd0);
    chk("rst_uop",   {27'd0, bus.alu_uop}, 32'd0);
    check_rf("rst_rf");

    // 1: MOV R1,#5
    issue(16'h8905);
    exp_rf[1] = 32'h5;
    chk("mov_rdy_dec", {31'd0, rdy_dec}, 32'd0);
    chk("mov_uop",     {27'd0, uop_ex}, 32'd8);
    chk("mov_rhs",     rhs_ex, 32'h5);
    chk("mov_done_ex", {31'd0, done_ex}, 32'd0);
    chk("mov_done_n3", {31'd0, done_wb}, 32'd1);
    chk("mov_err",     {31'd0, err_wb}, 32'd0);
    chk("mov_done_n4", {31'd0, done_idle}, 32'd0);
    rd(3'd1, rdv);
    chk("mov_r1", rdv, 32'h5);

    // 2: ADD R2,R1,R1
    issue(16'h1224);
    exp_rf[2] = 32'hA;
    chk("add_uop", {27'd0, uop_ex}, 32'd1);
    chk("add_lhs", lhs_ex, 32'h5);
    chk("add_rhs", rhs_ex, 32'h5);
    rd(3'd2, rdv);
    chk("add_r2", rdv, 32'hA);
    chk("add_flags", {28'd0, bus.flags}, 32'h0);

    // 3: CMP R1,R1 -> Z=1, C=1 (no borrow)
    issue(16'h5024);
    chk("cmp_uop",   {27'd0, uop_ex}, 32'd5);
    chk("cmp_done",  {31'd0, done_wb}, 32'd1);
    chk("cmp_flags", {28'd0, bus.flags}, 32'hC);
    check_rf("cmp_rf");

    // 4: illegal then NOP
    issue(16'hF000);
    chk("ill_uop",   {27'd0, uop_ex}, 32'd0);
    chk("ill_done",  {31'd0, done_wb}, 32'd1);
    chk("ill_err",   {31'd0, err_wb}, 32'd1);
    chk("ill_flags", {28'd0, bus.flags}, 32'hC);
    issue(16'h0000);
    chk("nop_uop",   {27'd0, uop_ex}, 32'd0);
    chk("nop_done",  {31'd0, done_wb}, 32'd1);
    chk("nop_err",   {31'd0, err_wb}, 32'd0);
    chk("nop_flags", {28'd0, bus.flags}, 32'hC);
    check_rf("ill_nop_rf");

    // 5: back-to-back ADD R3,#1 with valid held high
    rdy_hist        = 12'd0;
    accepts         = 0;
    dones           = 0;
    bus.instr       = 16'h1B01;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy_hist = {rdy_hist[10:0], bus.instr_ready};
      if (bus.instr_valid && bus.instr_ready) accepts++;
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
    exp_rf[3] = 32'd3;
    chk("b2b_ready_pattern", {20'd0, rdy_hist}, {20'd0, 12'b1000_1000_1000});
    chk("b2b_accepts", accepts, 32'd3);
    chk("b2b_dones",   dones, 32'd3);
    rd(3'd3, rdv);
    chk("b2b_r3", rdv, 32'd3);

    // 6: reset during EXEC of MOV R2,#0xFF
    bus.instr       = 16'h8AFF;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec_uop", {27'd0, bus.alu_uop}, 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst2_done",  {31'd0, bus.done}, 32'd0);
    chk("rst2_err",   {31'd0, bus.err}, 32'd0);
    chk("rst2_flags", {28'd0, bus.flags}, 32'd0);
    chk("rst2_uop",   {27'd0, bus.alu_uop}, 32'd0);
    chk("rst2_lhs",   bus.alu_lhs, 32'd0);
    chk("rst2_rhs",   bus.alu_rhs, 32'd0);
    @(posedge clk); #1;
    chk("rst2_no_wb", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'd0;
    check_rf("rst2_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
